seg7_scan_controller: RTL

//  Time-multiplexes NUM_DIGITS BCD digits onto one shared seg7 decoder and its digit-enable lines.

---
 rtl/seg7_scan_controller.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg7_scan_controller
// Purpose  : Time-multiplexes NUM_DIGITS BCD digits onto one shared seg7
//            decoder. Owns the scan timebase, the inter-digit blanking gap,
//            leading-zero blanking and a one-deep valid/ready load buffer.
//            New values are swapped in only at frame boundaries, so a frame
//            never mixes old and new digits.
// Ports    : clk, rst_n      - clock (rising edge), async active-low reset
//            ena             - scan enable, low holds the display dark (IDLE)
//            period_sel      - 0: slot = SCAN_COUNT, else {period_sel,6'b0}
//            lzb_en          - leading-zero blanking enable
//            value_valid/value_data/value_ready - load handshake
//            dec_digit/dec_blank - to the shared seg7 decoder
//            digit_en        - one-hot digit select, all 0 while blank
//            frame_done      - one-cycle pulse as each full frame completes
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_controller #(
  parameter int          NUM_DIGITS   = 4,
  parameter logic [23:0] SCAN_COUNT   = 24'd10_000,
  parameter logic [7:0]  BLANK_CYCLES = 8'd16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [7:0]              period_sel,
  input  logic                    lzb_en,
  input  logic                    value_valid,
  input  logic [4*NUM_DIGITS-1:0] value_data,
  output logic                    value_ready,
  output logic [3:0]              dec_digit,
  output logic                    dec_blank,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int              IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]       GAP_LAST = BLANK_CYCLES - 8'd1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Scan state
  logic [1:0]       r_state,    w_state_nx;
  logic [IDX_W-1:0] r_idx,      w_idx_nx;
  logic [23:0]      r_slot_cnt, w_slot_nx;
  logic [7:0]       r_gap_cnt,  w_gap_nx;
  logic [23:0]      r_period,   w_period_nx;
  logic [23:0]      w_period_sel_val;
  logic [IDX_W-1:0] w_adv_idx;
  logic             w_wrap;
  logic             w_enter_on;

  // Load buffer
  logic [4*NUM_DIGITS-1:0] r_disp, w_disp_nx;
  logic [4*NUM_DIGITS-1:0] r_pend;
  logic                    r_pending;
  logic                    w_accept;
  logic                    w_transfer;

  // Registered outputs and their next values
  logic [3:0]            r_dec_digit, w_dec_digit_nx;
  logic                  r_dec_blank, w_dec_blank_nx;
  logic [NUM_DIGITS-1:0] r_digit_en,  w_digit_en_nx;
  logic                  r_frame_done, w_frame_done_nx;

  // Leading-zero detection on the digits that will be displayed next cycle
  logic [3:0]            w_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_zero;
  logic [NUM_DIGITS-1:0] w_upper_zero;
  logic                  w_lzb;

  assign w_period_sel_val = (period_sel == 8'd0) ? SCAN_COUNT : {10'd0, period_sel, 6'd0};
  assign w_adv_idx        = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nx  = r_state;
    w_idx_nx    = r_idx;
    w_slot_nx   = r_slot_cnt;
    w_gap_nx    = r_gap_cnt;
    w_period_nx = r_period;
    w_wrap      = 1'b0;
    w_enter_on  = 1'b0;
    if (!ena) begin
      // Dropping enable abandons the frame without a frame_done pulse.
      w_state_nx = ST_IDLE;
      w_idx_nx   = '0;
      w_slot_nx  = '0;
      w_gap_nx   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nx = ST_ON;
          w_idx_nx   = '0;
          w_slot_nx  = '0;
          w_gap_nx   = '0;
          w_enter_on = 1'b1;
        end
        ST_ON: begin
          if (r_slot_cnt == r_period - 24'd1) begin
            w_slot_nx = '0;
            if (BLANK_CYCLES == 8'd0) begin
              w_state_nx = ST_ON;
              w_idx_nx   = w_adv_idx;
              w_wrap     = (r_idx == LAST_IDX);
              w_enter_on = 1'b1;
            end else begin
              w_state_nx = ST_GAP;
              w_gap_nx   = '0;
            end
          end else begin
            w_slot_nx = r_slot_cnt + 24'd1;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            w_state_nx = ST_ON;
            w_idx_nx   = w_adv_idx;
            w_wrap     = (r_idx == LAST_IDX);
            w_gap_nx   = '0;
            w_slot_nx  = '0;
            w_enter_on = 1'b1;
          end else begin
            w_gap_nx = r_gap_cnt + 8'd1;
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_idx_nx   = '0;
          w_slot_nx  = '0;
          w_gap_nx   = '0;
        end
      endcase
    end
    // The slot length is latched as each ON slot starts, so a period_sel
    // change never stretches or truncates the slot already running.
    if (w_enter_on) begin
      w_period_nx = w_period_sel_val;
    end
  end

  // Load buffer: pending blocks new accepts; its contents move to the display
  // register at a frame wrap, or on any edge while IDLE.
  assign w_accept    = value_valid & ~r_pending;
  assign w_transfer  = r_pending & ((r_state == ST_IDLE) | w_wrap);
  assign w_disp_nx   = w_transfer ? r_pend : r_disp;
  assign value_ready = ~r_pending;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_digit[gi] = w_disp_nx[4*gi +: 4];
      assign w_zero[gi]  = (w_digit[gi] == 4'd0);
    end
  endgenerate

  // w_upper_zero[i] is set when digit i and every more significant digit are 0.
  always_comb begin
    w_upper_zero                 = '0;
    w_upper_zero[NUM_DIGITS-1]   = w_zero[NUM_DIGITS-1];
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      w_upper_zero[i] = w_zero[i] & w_upper_zero[i+1];
    end
  end

  // --------------------------------------------------------------------------
  // Output logic, computed from next-state values so the registered outputs
  // line up with the state they describe.
  // --------------------------------------------------------------------------
  always_comb begin
    w_dec_digit_nx  = 4'd0;
    w_dec_blank_nx  = 1'b1;
    w_digit_en_nx   = '0;
    w_frame_done_nx = w_wrap;
    w_lzb           = 1'b0;
    if (w_state_nx == ST_ON) begin
      w_lzb          = lzb_en && (w_idx_nx != '0) && w_upper_zero[w_idx_nx];
      w_dec_digit_nx = w_digit[w_idx_nx];
      if (!w_lzb) begin
        w_dec_blank_nx = 1'b0;
        w_digit_en_nx  = NUM_DIGITS'(1) << w_idx_nx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_slot_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_period     <= '0;
      r_disp       <= '0;
      r_pend       <= '0;
      r_pending    <= 1'b0;
      r_dec_digit  <= 4'd0;
      r_dec_blank  <= 1'b1;
      r_digit_en   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_idx        <= w_idx_nx;
      r_slot_cnt   <= w_slot_nx;
      r_gap_cnt    <= w_gap_nx;
      r_period     <= w_period_nx;
      r_disp       <= w_disp_nx;
      if (w_accept) begin
        r_pend    <= value_data;
        r_pending <= 1'b1;
      end else if (w_transfer) begin
        r_pending <= 1'b0;
      end
      r_dec_digit  <= w_dec_digit_nx;
      r_dec_blank  <= w_dec_blank_nx;
      r_digit_en   <= w_digit_en_nx;
      r_frame_done <= w_frame_done_nx;
    end
  end

  assign dec_digit  = r_dec_digit;
  assign dec_blank  = r_dec_blank;
  assign digit_en   = r_digit_en;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire
